// File: rtl/wavetable_reader.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_reader
// Brief    : Fills a 4K x 20 wavetable RAM from a write stream and plays it back
//            through a phase accumulator. Define WT_INTERP_EN for linear interpolation.
// Revision : 1.0
// ============================================================================
module wavetable_reader #(
    parameter int PHASE_W = 24,
    parameter int DATA_W  = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               play_en,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [DATA_W-1:0]  load_data,
    output logic               load_ready,
    output logic               load_done,
    output logic               ram_load,
    output logic [11:0]        ram_sel,
    output logic [DATA_W-1:0]  ram_in,
    input  logic [DATA_W-1:0]  ram_out,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun
);

    localparam int         c_ADDR_W    = 12;
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LOAD      = 3'd1;
    localparam logic [2:0] c_WAIT_TICK = 3'd2;
    localparam logic [2:0] c_FETCH0    = 3'd3;
    localparam logic [2:0] c_HOLD      = 3'd5;
`ifdef WT_INTERP_EN
    localparam logic [2:0] c_FETCH1    = 3'd4;
    localparam int         c_PROD_W    = DATA_W + 10;
`endif

    logic [2:0]          state_q,   state_d;
    logic [PHASE_W-1:0]  phase_q,   phase_d;
    logic [c_ADDR_W-1:0] wcnt_q,    wcnt_d;
    logic [c_ADDR_W-1:0] rsel_q,    rsel_d;
    logic [DATA_W-1:0]   sample_q,  sample_d;
    logic                overrun_q, overrun_d;
    logic                done_q,    done_d;
    logic                w_in_load;
    logic                w_busy;

`ifdef WT_INTERP_EN
    logic [DATA_W-1:0]          s0_q,   s0_d;
    logic [7:0]                 frac_q, frac_d;
    logic signed [c_PROD_W-1:0] w_diff;
    logic signed [c_PROD_W-1:0] w_frac;
    logic signed [c_PROD_W-1:0] w_prod;
    logic [DATA_W-1:0]          w_step;

    // s1 is read straight off the RAM in FETCH1; the step always lies between s0 and s1
    assign w_diff = $signed({{10{ram_out[DATA_W-1]}}, ram_out}) - $signed({{10{s0_q[DATA_W-1]}}, s0_q});
    assign w_frac = $signed({{(c_PROD_W-8){1'b0}}, frac_q});
    assign w_prod = w_diff * w_frac;
    assign w_step = DATA_W'(w_prod >>> 8);
    assign w_busy = (state_q == c_FETCH0) || (state_q == c_FETCH1) || (state_q == c_HOLD);
`else
    assign w_busy = (state_q == c_FETCH0) || (state_q == c_HOLD);
`endif

    assign w_in_load    = (state_q == c_LOAD);
    assign load_ready   = w_in_load;
    assign ram_load     = w_in_load & load_valid;
    assign ram_sel      = w_in_load ? wcnt_q : rsel_q;
    assign ram_in       = w_in_load ? load_data : '0;
    assign load_done    = done_q;
    assign sample_out   = sample_q;
    assign sample_valid = (state_q == c_HOLD);
    assign overrun      = overrun_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wcnt_d    = wcnt_q;
        rsel_d    = rsel_q;
        sample_d  = sample_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (sample_tick & w_busy);
`ifdef WT_INTERP_EN
        s0_d      = s0_q;
        frac_d    = frac_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (load_start) begin
                    state_d = c_LOAD;
                    wcnt_d  = '0;
                end else if (play_en) begin
                    state_d = c_WAIT_TICK;
                end
            end
            c_LOAD: begin
                if (load_valid) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == '1) begin
                        done_d  = 1'b1;
                        state_d = c_IDLE;
                    end
                end
            end
            c_WAIT_TICK: begin
                // A load request wins over a coincident tick, which is dropped
                if (load_start) begin
                    state_d = c_LOAD;
                    wcnt_d  = '0;
                end else if (!play_en) begin
                    state_d = c_IDLE;
                end else if (sample_tick) begin
                    rsel_d  = phase_q[PHASE_W-1 -: c_ADDR_W];
                    phase_d = phase_q + phase_inc;
`ifdef WT_INTERP_EN
                    frac_d  = phase_q[PHASE_W-c_ADDR_W-1 -: 8];
`endif
                    state_d = c_FETCH0;
                end
            end
            c_FETCH0: begin
`ifdef WT_INTERP_EN
                s0_d    = ram_out;
                rsel_d  = rsel_q + 1'b1;
                state_d = c_FETCH1;
`else
                sample_d = ram_out;
                state_d  = c_HOLD;
`endif
            end
`ifdef WT_INTERP_EN
            c_FETCH1: begin
                sample_d = s0_q + w_step;
                state_d  = c_HOLD;
            end
`endif
            c_HOLD: begin
                if (sample_ready) begin
                    state_d = c_WAIT_TICK;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= c_IDLE;
            phase_q   <= '0;
            wcnt_q    <= '0;
            rsel_q    <= '0;
            sample_q  <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef WT_INTERP_EN
            s0_q      <= '0;
            frac_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wcnt_q    <= wcnt_d;
            rsel_q    <= rsel_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
`ifdef WT_INTERP_EN
            s0_q      <= s0_d;
            frac_q    <= frac_d;
`endif
        end
    end

endmodule
`default_nettype wire
